// File: rtl/key_filter.sv
// Debounces an active-low key/coin sensor: two-flop synchronizer, four-state filter FSM,
// a registered one-cycle press pulse and a registered debounced level.
module key_filter #(
    parameter int unsigned      CNT_W   = 20,
    parameter logic [CNT_W-1:0] CNT_MAX = 20'd999_999
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_in,
    output logic po_money,
    output logic key_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILT_DN = 2'd1,
        DOWN    = 2'd2,
        FILT_UP = 2'd3
    } state_t;

    // Last count value before a filter state commits; CNT_MAX = 1 gives a one-cycle filter.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_MAX - CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             key_s1_q, key_s2_q;
    logic             po_money_q, po_money_d;
    logic             key_state_q, key_state_d;

    // Synchronizer resets to the released level so a reset never looks like a press.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            key_s1_q <= 1'b1;
            key_s2_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments keep the two flops distinct; blocking would collapse the chain.
            key_s1_q <= key_in;
            key_s2_q <= key_s1_q;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            po_money_q  <= 1'b0;
            key_state_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            po_money_q  <= po_money_d;
            key_state_q <= key_state_d;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first, so no path through the case can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        po_money_d  = 1'b0;
        key_state_d = key_state_q;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!key_s2_q) state_d = FILT_DN;
            end
            FILT_DN: begin
                if (key_s2_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = DOWN;
                    cnt_d       = '0;
                    po_money_d  = 1'b1;
                    key_state_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DOWN: begin
                cnt_d = '0;
                if (key_s2_q) state_d = FILT_UP;
            end
            FILT_UP: begin
                // A low sample here is release bounce: back to DOWN without a new pulse.
                if (!key_s2_q) begin
                    state_d = DOWN;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    key_state_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign po_money  = po_money_q;
    assign key_state = key_state_q;

endmodule

// File: tb/tb_key_filter.sv
// Bench for key_filter with CNT_MAX = 4: vector table, hand-timed corner sequences and
// random bouncing stimulus, all checked against a run-length debounce model.
module tb_key_filter;

    localparam int unsigned CNT_W   = 20;
    localparam logic [19:0] CNT_MAX = 20'd4;
    localparam int          LAT     = 7;   // CNT_MAX + 3 edges from first low sample

    logic sys_clk;
    logic sys_rst_n;
    logic key_in;
    logic po_money;
    logic key_state;

    int checks    = 0;
    int failures  = 0;
    int pulse_cnt = 0;

    key_filter #(.CNT_W(CNT_W), .CNT_MAX(CNT_MAX)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key_in    (key_in),
        .po_money  (po_money),
        .key_state (key_state)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Reference: the level the filter sees lags key_in by two samples; the debounced
    // level flips once that lagged input has disagreed with it for CNT_MAX+1 edges.
    logic hist[$];
    logic m_level;
    logic m_pulse;
    int   run;

    task automatic model_reset();
        hist    = '{1'b1, 1'b1};
        m_level = 1'b1;
        m_pulse = 1'b0;
        run     = 0;
    endtask

    task automatic model_edge(input logic v);
        logic seen;
        seen = hist[1];
        hist.push_front(v);
        void'(hist.pop_back());
        m_pulse = 1'b0;
        if (seen != m_level) run++;
        else run = 0;
        if (run == int'(CNT_MAX) + 1) begin
            m_pulse = m_level;
            m_level = seen;
            run     = 0;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic v);
        key_in = v;
        @(posedge sys_clk);
        model_edge(v);
        #1;
        check("model po_money", {31'd0, po_money}, {31'd0, m_pulse});
        check("model key_state", {31'd0, key_state}, {31'd0, m_level});
        if (po_money === 1'b1) pulse_cnt++;
    endtask

    task automatic hold(input logic v, input int n);
        for (int i = 0; i < n; i++) step(v);
    endtask

    typedef struct {
        int   low1;
        int   high1;
        int   low2;
        int   high2;
        int   exp_pulses;
        logic exp_state;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{20, 0, 0, 20, 1, 1'b1};  // clean press/release
        vecs[1] = '{3, 0, 0, 10, 0, 1'b1};   // press glitch
        vecs[2] = '{2, 2, 20, 20, 1, 1'b1};  // press bounce
        vecs[3] = '{4, 0, 0, 10, 0, 1'b1};   // one sample short of the threshold
        vecs[4] = '{5, 0, 0, 10, 1, 1'b1};   // exactly at the threshold

        sys_rst_n = 1'b0;
        key_in    = 1'b1;
        model_reset();

        // Reset holds outputs idle while key_in toggles.
        for (int i = 0; i < 6; i++) begin
            key_in = logic'(i % 2);
            @(posedge sys_clk);
            #1;
            check("reset po_money", {31'd0, po_money}, 32'd0);
            check("reset key_state", {31'd0, key_state}, 32'd1);
        end
        key_in    = 1'b1;
        sys_rst_n = 1'b1;
        hold(1'b1, 5);

        // Clean press: pulse and level change exactly at edge LAT.
        for (int e = 1; e <= 20; e++) begin
            step(1'b0);
            check("press pulse timing", {31'd0, po_money}, (e == LAT) ? 32'd1 : 32'd0);
            check("press level timing", {31'd0, key_state}, (e >= LAT) ? 32'd0 : 32'd1);
        end
        // Release bounce while pressed: no change, no pulse.
        pulse_cnt = 0;
        hold(1'b1, 2);
        hold(1'b0, 10);
        check("release bounce pulses", pulse_cnt, 0);
        check("release bounce level", {31'd0, key_state}, 32'd0);
        // Clean release: level returns at edge LAT, never a pulse.
        for (int e = 1; e <= 20; e++) begin
            step(1'b1);
            check("release pulse", {31'd0, po_money}, 32'd0);
            check("release level timing", {31'd0, key_state}, (e >= LAT) ? 32'd1 : 32'd0);
        end

        // Vector table.
        foreach (vecs[i]) begin
            pulse_cnt = 0;
            hold(1'b0, vecs[i].low1);
            hold(1'b1, vecs[i].high1);
            hold(1'b0, vecs[i].low2);
            hold(1'b1, vecs[i].high2);
            check($sformatf("vec%0d pulses", i), pulse_cnt, vecs[i].exp_pulses);
            check($sformatf("vec%0d level", i), {31'd0, key_state}, {31'd0, vecs[i].exp_state});
        end

        // Reset in FILT_DN at cnt = 2, key_in kept low throughout.
        hold(1'b0, 5);
        check("pre-reset no pulse", {31'd0, po_money}, 32'd0);
        #2;
        sys_rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            @(posedge sys_clk);
            #1;
            check("mid-filter reset po_money", {31'd0, po_money}, 32'd0);
            check("mid-filter reset key_state", {31'd0, key_state}, 32'd1);
        end
        sys_rst_n = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            step(1'b0);
            check("post-reset pulse timing", {31'd0, po_money}, (e == LAT) ? 32'd1 : 32'd0);
        end
        hold(1'b1, 12);
        pulse_cnt = 0;
        for (int p = 0; p < 3; p++) begin
            hold(1'b0, 10);
            hold(1'b1, 10);
        end
        check("three presses", pulse_cnt, 3);

        // Random bouncing segments; the model checks every edge.
        for (int s = 0; s < 60; s++) begin
            hold(logic'(s % 2), int'($urandom_range(1, 9)));
        end
        hold(1'b1, 12);
        check("random end level", {31'd0, key_state}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
